// File: rtl/alu_issue_fifo.sv
// Issue stage for a combinational ALU: command FIFO feeding the ALU operands,
// with a registered valid/ready result stage for one-op-per-cycle throughput.
module alu_issue_fifo #(
    parameter int unsigned BW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BW-1:0]                in_a,
    input  logic [BW-1:0]                in_b,
    input  logic [2:0]                   in_op,
    output logic [BW-1:0]                alu_a,
    output logic [BW-1:0]                alu_b,
    output logic [2:0]                   alu_op,
    input  logic [BW-1:0]                alu_result,
    input  logic                         alu_zero,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BW-1:0]                out_result,
    output logic                         out_zero,
    output logic [2:0]                   out_op,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [2:0]    op;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
    } cmd_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          push;
    logic          issue;

    // Ready depends only on registered occupancy; a same-cycle pop does not help.
    assign in_ready = (count != CW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = in_valid && in_ready && !flush;
    assign issue    = !empty && (!out_valid || out_ready) && !flush;

    // Head is masked to zero when empty so stale entries never reach the ALU.
    assign head   = empty ? '0 : mem[rd_ptr];
    assign alu_a  = head.a;
    assign alu_b  = head.b;
    assign alu_op = head.op;

    // Storage array needs no reset: entries are only visible when counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_op     <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !issue) begin
                count <= count + CW'(1);
            end else if (!push && issue) begin
                count <= count - CW'(1);
            end
            // Output stage: load on issue, drop valid when drained with nothing behind.
            if (issue) begin
                out_valid  <= 1'b1;
                out_result <= alu_result;
                out_zero   <= alu_zero;
                out_op     <= alu_op;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_fifo.sv
// Randomised and directed bench for alu_issue_fifo against a queue-based model,
// with a behavioural ALU driving the DUT's alu_result/alu_zero inputs.
module tb_alu_issue_fifo;

    localparam int unsigned BW    = 8;
    localparam int unsigned DEPTH = 4;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                           OP_XOR = 3'd4, OP_NOT = 3'd5, OP_SLL = 3'd6, OP_SRL = 3'd7;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready, out_zero, alu_zero;
    logic [BW-1:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
    logic [2:0]    in_op, alu_op, out_op;
    logic [2:0]    count;

    alu_issue_fifo #(.BW(BW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_op(out_op),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOT:  return ~a;
            OP_SLL:  return a << b[2:0];
            default: return a >> b[2:0];
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_result == 8'h00);

    typedef struct packed { logic [2:0] op; logic [7:0] a; logic [7:0] b; } cmd_t;
    typedef struct packed { logic [7:0] res; logic zero; logic [2:0] op; } res_t;

    cmd_t       q[$];
    res_t       dlv[$];
    bit         mv;
    logic [7:0] mres;
    logic       mz;
    logic [2:0] mop;
    bit         last_acc;
    bit         tgl;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mv = 0; mres = '0; mz = 0; mop = '0;
    endtask

    task automatic compare_all();
        cmd_t h;
        h = (q.size() != 0) ? q[0] : '0;
        check("count", 32'(count), 32'(q.size()));
        check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        check("out_valid", 32'(out_valid), 32'(mv));
        check("out_result", 32'(out_result), 32'(mres));
        check("out_zero", 32'(out_zero), 32'(mz));
        check("out_op", 32'(out_op), 32'(mop));
        check("alu_a", 32'(alu_a), 32'(h.a));
        check("alu_b", 32'(alu_b), 32'(h.b));
        check("alu_op", 32'(alu_op), 32'(h.op));
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare just after.
    task automatic cycle(input bit v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit ordy, input bit fl);
        bit   acc, iss;
        cmd_t h;
        @(negedge clk);
        in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = ordy; flush = fl;
        acc = v && (q.size() != DEPTH);
        iss = (q.size() != 0) && (!mv || ordy);
        @(posedge clk);
        if (fl) begin
            q.delete();
            mv  = 0;
            acc = 0;
        end else begin
            if (mv && ordy) dlv.push_back('{res: mres, zero: mz, op: mop});
            if (iss) begin
                h    = q.pop_front();
                mres = alu_f(h.op, h.a, h.b);
                mz   = (mres == 8'h00);
                mop  = h.op;
                mv   = 1;
            end else if (mv && ordy) begin
                mv = 0;
            end
            if (acc) q.push_back('{op: op, a: a, b: b});
        end
        last_acc = acc;
        #1 compare_all();
    endtask

    // rmode: 0/1 = out_ready held at that value, 2 = toggles every cycle.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int rmode);
        int n = 0;
        do begin
            if (rmode == 2) tgl = ~tgl;
            cycle(1, op, a, b, (rmode == 2) ? tgl : (rmode == 1), 0);
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) check("send_timeout", 32'(n), 32'(0));
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, ordy, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || mv) && n < 40) begin
            cycle(0, '0, '0, '0, 1, 0);
            n++;
        end
        if (q.size() != 0 || mv) check("drain_timeout", 32'(n), 32'(0));
    endtask

    task automatic check_dlv(input int idx, input logic [7:0] res, input logic zero, input logic [2:0] op);
        if (idx >= dlv.size()) begin
            check("dlv_missing", 32'(dlv.size()), 32'(idx + 1));
        end else begin
            check($sformatf("dlv%0d_res", idx), 32'(dlv[idx].res), 32'(res));
            check($sformatf("dlv%0d_zero", idx), 32'(dlv[idx].zero), 32'(zero));
            check($sformatf("dlv%0d_op", idx), 32'(dlv[idx].op), 32'(op));
        end
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; in_a = '0; in_b = '0; in_op = '0; out_ready = 0;
        tgl = 0;
        model_reset();
        #1;
        check("rst_count", 32'(count), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_alu_a", 32'(alu_a), 32'(0));
        repeat (2) @(negedge clk);
        rst = 0;

        // Single ADD with wrap-around of the 8-bit sum.
        send(OP_ADD, 8'hF0, 8'h20, 1);
        check("single_alu_a", 32'(alu_a), 32'hF0);
        idle(1, 1);
        check("single_valid", 32'(out_valid), 32'(1));
        check("single_res", 32'(out_result), 32'h10);
        check("single_zero", 32'(out_zero), 32'(0));
        check("single_op", 32'(out_op), 32'(OP_ADD));
        drain();

        // Back-to-back ops, one result per cycle in order.
        dlv.delete();
        send(OP_SUB, 8'h05, 8'h05, 1);
        send(OP_SLL, 8'h81, 8'h03, 1);
        send(OP_SRL, 8'h81, 8'h03, 1);
        send(OP_NOT, 8'h0F, 8'h00, 1);
        check("b2b_count", 32'(count), 32'(1));
        drain();
        check("b2b_n", 32'(dlv.size()), 32'(4));
        check_dlv(0, 8'h00, 1, OP_SUB);
        check_dlv(1, 8'h08, 0, OP_SLL);
        check_dlv(2, 8'h10, 0, OP_SRL);
        check_dlv(3, 8'hF0, 0, OP_NOT);

        // Back-pressure: 5 absorbed, 6th held until out_ready rises.
        dlv.delete();
        for (int i = 0; i < 5; i++) send(OP_ADD, 8'(i), 8'h10, 0);
        cycle(1, OP_ADD, 8'd5, 8'h10, 0, 0);
        check("full_acc6", 32'(last_acc), 32'(0));
        check("full_count", 32'(count), 32'(4));
        check("full_in_ready", 32'(in_ready), 32'(0));
        cycle(1, OP_ADD, 8'd5, 8'h10, 1, 0);
        check("full_ready_back", 32'(in_ready), 32'(1));
        send(OP_ADD, 8'd5, 8'h10, 1);
        drain();
        check("full_n", 32'(dlv.size()), 32'(6));
        for (int i = 0; i < 6; i++) check_dlv(i, 8'(i + 16), 0, OP_ADD);

        // Wrap-around with toggling out_ready.
        dlv.delete();
        for (int i = 0; i < 10; i++) send(OP_XOR, 8'(i), 8'hFF, 2);
        drain();
        check("wrap_n", 32'(dlv.size()), 32'(10));
        for (int i = 0; i < 10; i++) check_dlv(i, ~8'(i), 0, OP_XOR);

        // Flush with 3 queued plus a valid output; offered command is dropped.
        dlv.delete();
        for (int i = 0; i < 4; i++) send(OP_OR, 8'(i), 8'h40, 0);
        check("flush_pre_count", 32'(count), 32'(3));
        check("flush_pre_valid", 32'(out_valid), 32'(1));
        cycle(1, OP_AND, 8'hAA, 8'hFF, 0, 1);
        check("flush_count", 32'(count), 32'(0));
        check("flush_valid", 32'(out_valid), 32'(0));
        check("flush_res_hold", 32'(out_result), 32'h40);
        idle(2, 1);
        send(OP_AND, 8'h3C, 8'h0F, 1);
        drain();
        check("flush_n", 32'(dlv.size()), 32'(1));
        check_dlv(0, 8'h0C, 0, OP_AND);

        // Randomised traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 3'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), $urandom_range(0, 31) == 0);
        end
        drain();

        // Asynchronous reset mid-stream with 3 queued entries.
        for (int i = 0; i < 4; i++) send(OP_SUB, 8'h80, 8'(i), 0);
        check("arst_pre_count", 32'(count), 32'(3));
        #1 rst = 1; in_valid = 0;
        #1;
        check("arst_count", 32'(count), 32'(0));
        check("arst_valid", 32'(out_valid), 32'(0));
        check("arst_res", 32'(out_result), 32'(0));
        check("arst_in_ready", 32'(in_ready), 32'(1));
        check("arst_alu_op", 32'(alu_op), 32'(0));
        @(negedge clk);
        rst = 0;
        model_reset();
        dlv.delete();
        send(OP_ADD, 8'h01, 8'h02, 1);
        drain();
        check_dlv(0, 8'h03, 0, OP_ADD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0t expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
